// File: rtl/xcrypto_pkg.sv
// Shared xcrypto definitions: multiplier FSM state encoding and packed-lane geometry.
package xcrypto_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } mul_state_e;

    // Lane width W for a one-hot pack width; non-one-hot codes fall back to 32.
    function automatic logic [5:0] pw_to_width(input logic [4:0] pw);
        case (pw)
            5'b00001: pw_to_width = 6'd32;
            5'b00010: pw_to_width = 6'd16;
            5'b00100: pw_to_width = 6'd8;
            5'b01000: pw_to_width = 6'd4;
            5'b10000: pw_to_width = 6'd2;
            default:  pw_to_width = 6'd32;
        endcase
    endfunction

    function automatic logic [4:0] lane_mask(input logic [4:0] pw);
        logic [5:0] w;
        w = pw_to_width(pw) - 6'd1;
        lane_mask = w[4:0];
    endfunction

endpackage

// File: rtl/p_addsub.sv
// Packed per-lane adder/subtractor; carries never cross lane boundaries,
// and c_en=0 turns every lane into a plain XOR.
module p_addsub
    import xcrypto_pkg::*;
(
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    input  logic [4:0]  pw,
    input  logic        cin,
    input  logic        sub,
    input  logic        c_en,
    output logic [31:0] c_out,
    output logic [31:0] result
);

    logic [4:0] mask;
    logic       carry;
    logic       ci;
    logic       b;

    always_comb begin
        mask   = lane_mask(pw);
        c_out  = '0;
        result = '0;
        carry  = 1'b0;
        ci     = 1'b0;
        b      = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ci        = ((5'(i) & mask) == 5'd0) ? (cin | sub) : carry;
            b         = rhs[i] ^ sub;
            result[i] = lhs[i] ^ b ^ ci;
            c_out[i]  = c_en & ((lhs[i] & b) | (lhs[i] & ci) | (b & ci));
            carry     = c_out[i];
        end
    end

endmodule

// File: rtl/p_mul_iter.sv
// Iterative packed shift-add multiplier, one bit per lane per cycle.
// Optional carry-less mode (clmul port) when P_MUL_ITER_CLMUL_EN is defined.
module p_mul_iter
    import xcrypto_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        valid,
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    input  logic [4:0]  pw,
    input  logic        high,
`ifdef P_MUL_ITER_CLMUL_EN
    input  logic        clmul,
`endif
    output logic        ready,
    output logic [31:0] result
);

    mul_state_e  state;
    logic [4:0]  count;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;

    logic [4:0]  mask;
    logic [31:0] addend;
    logic [31:0] sum;
    logic [31:0] c_out;
    logic [32:0] sum_ext;
    logic [32:0] lo_ext;
    logic [31:0] hi_nxt;
    logic [31:0] lo_nxt;
    logic [4:0]  base;
    logic        c_en;

`ifdef P_MUL_ITER_CLMUL_EN
    assign c_en = ~clmul;
`else
    assign c_en = 1'b1;
`endif

    assign mask = lane_mask(pw);

    always_comb begin
        addend = '0;
        base   = '0;
        for (int i = 0; i < 32; i++) begin
            base      = 5'(i) & ~mask;
            addend[i] = lhs[i] & acc_lo[base];
        end
    end

    p_addsub u_addsub (
        .lhs    (acc_hi),
        .rhs    (addend),
        .pw     (pw),
        .cin    (1'b0),
        .sub    (1'b0),
        .c_en   (c_en),
        .c_out  (c_out),
        .result (sum)
    );

    // Per-lane right shift of {carry-out, sum, acc_lo}.
    always_comb begin
        sum_ext = {1'b0, sum};
        lo_ext  = {1'b0, acc_lo};
        hi_nxt  = '0;
        lo_nxt  = '0;
        for (int i = 0; i < 32; i++) begin
            if ((5'(i) & mask) == mask) begin
                hi_nxt[i] = c_out[i];
                lo_nxt[i] = sum[5'(i) & ~mask];
            end else begin
                hi_nxt[i] = sum_ext[i+1];
                lo_nxt[i] = lo_ext[i+1];
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state  <= StIdle;
            count  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            ready  <= 1'b0;
            result <= '0;
        end else begin
            ready  <= 1'b0;
            result <= '0;
            if (flush) begin
                state <= StIdle;
            end else begin
                case (state)
                    StIdle: begin
                        if (valid) begin
                            state  <= StBusy;
                            acc_hi <= '0;
                            acc_lo <= rhs;
                            count  <= '0;
                        end
                    end
                    StBusy: begin
                        acc_hi <= hi_nxt;
                        acc_lo <= lo_nxt;
                        count  <= count + 5'd1;
                        if (count == mask) begin
                            state  <= StDone;
                            ready  <= 1'b1;
                            result <= high ? hi_nxt : lo_nxt;
                        end
                    end
                    StDone:  state <= StIdle;
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_p_mul_iter.sv
// Directed self-checking bench for p_mul_iter (carry-less case when P_MUL_ITER_CLMUL_EN is set).
module tb_p_mul_iter;

    logic        g_clk    = 1'b0;
    logic        g_resetn = 1'b0;
    logic        flush    = 1'b0;
    logic        valid    = 1'b0;
    logic        high     = 1'b0;
    logic [31:0] lhs      = '0;
    logic [31:0] rhs      = '0;
    logic [4:0]  pw       = 5'b00001;
    logic        ready;
    logic [31:0] result;
`ifdef P_MUL_ITER_CLMUL_EN
    logic        clmul    = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 g_clk = ~g_clk;

    p_mul_iter dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .flush    (flush),
        .valid    (valid),
        .lhs      (lhs),
        .rhs      (rhs),
        .pw       (pw),
        .high     (high),
`ifdef P_MUL_ITER_CLMUL_EN
        .clmul    (clmul),
`endif
        .ready    (ready),
        .result   (result)
    );

    // Issue one request from IDLE; lat counts edges from the accepting edge
    // up to the one that raises ready (-1 on timeout).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] p,
                          input logic h, output logic [31:0] res, output int lat,
                          output bit leak);
        lhs   = a;
        rhs   = b;
        pw    = p;
        high  = h;
        valid = 1'b1;
        leak  = 1'b0;
        @(posedge g_clk); #1;
        lat = 1;
        while (!ready && lat < 40) begin
            if (result !== 32'h0) leak = 1'b1;
            @(posedge g_clk); #1;
            lat++;
        end
        res   = result;
        valid = 1'b0;
        if (!ready) lat = -1;
    endtask

    task automatic test_reset();
        g_resetn = 1'b0;
        repeat (3) @(posedge g_clk);
        #1;
        total++;
        if (ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready: got %b want 0", ready);
        end
        total++;
        if (result !== 32'h0) begin
            bad++; $display("FAIL reset_result: got %h want 00000000", result);
        end
        g_resetn = 1'b1;
        @(posedge g_clk); #1;
    endtask

    task automatic test_w32_small();
        logic [31:0] r; int lat; bit leak;
        run_op(32'd3, 32'd5, 5'b00001, 1'b0, r, lat, leak);
        total++;
        if (r !== 32'h0000000F) begin
            bad++; $display("FAIL w32_3x5: got %h want 0000000f", r);
        end
        total++;
        if (lat !== 33) begin
            bad++; $display("FAIL w32_latency: got %0d want 33", lat);
        end
        total++;
        if (leak) begin
            bad++; $display("FAIL w32_result_outside_done: got nonzero want 0");
        end
        @(posedge g_clk); #1;
        total++;
        if (ready !== 1'b0 || result !== 32'h0) begin
            bad++; $display("FAIL ready_pulse: got ready=%b result=%h want 0/0", ready, result);
        end
    endtask

    task automatic test_w32_max();
        logic [31:0] r; int lat; bit leak;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00001, 1'b1, r, lat, leak);
        @(posedge g_clk); #1;
        total++;
        if (r !== 32'hFFFFFFFE) begin
            bad++; $display("FAIL w32_max_hi: got %h want fffffffe", r);
        end
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00001, 1'b0, r, lat, leak);
        @(posedge g_clk); #1;
        total++;
        if (r !== 32'h00000001) begin
            bad++; $display("FAIL w32_max_lo: got %h want 00000001", r);
        end
    endtask

    task automatic test_narrow_lanes();
        logic [31:0] r; int lat; bit leak;
        run_op(32'h00030002, 32'h00040005, 5'b00010, 1'b0, r, lat, leak);
        @(posedge g_clk); #1;
        total++;
        if (r !== 32'h000C000A) begin
            bad++; $display("FAIL w16_lo: got %h want 000c000a", r);
        end
        total++;
        if (lat !== 17) begin
            bad++; $display("FAIL w16_latency: got %0d want 17", lat);
        end
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00100, 1'b1, r, lat, leak);
        @(posedge g_clk); #1;
        total++;
        if (r !== 32'hFEFEFEFE) begin
            bad++; $display("FAIL w8_hi: got %h want fefefefe", r);
        end
        total++;
        if (lat !== 9) begin
            bad++; $display("FAIL w8_latency: got %0d want 9", lat);
        end
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 5'b01000, 1'b0, r, lat, leak);
        @(posedge g_clk); #1;
        total++;
        if (r !== 32'h11111111) begin
            bad++; $display("FAIL w4_lo: got %h want 11111111", r);
        end
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 5'b10000, 1'b1, r, lat, leak);
        @(posedge g_clk); #1;
        total++;
        if (r !== 32'hAAAAAAAA) begin
            bad++; $display("FAIL w2_hi: got %h want aaaaaaaa", r);
        end
        total++;
        if (lat !== 3) begin
            bad++; $display("FAIL w2_latency: got %0d want 3", lat);
        end
    endtask

    task automatic test_flush();
        logic [31:0] r; int lat; bit leak; bit seen;
        lhs = 32'd7; rhs = 32'd9; pw = 5'b00001; high = 1'b0; valid = 1'b1;
        @(posedge g_clk); #1;
        repeat (4) @(posedge g_clk);
        #1;
        flush = 1'b1; valid = 1'b0;
        @(posedge g_clk); #1;
        flush = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            if (ready) seen = 1'b1;
            @(posedge g_clk); #1;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL flush_no_ready: got ready pulse want none");
        end
        run_op(32'd3, 32'd5, 5'b00001, 1'b0, r, lat, leak);
        @(posedge g_clk); #1;
        total++;
        if (r !== 32'h0000000F || lat !== 33) begin
            bad++; $display("FAIL after_flush: got %h lat %0d want 0000000f lat 33", r, lat);
        end
    endtask

    task automatic test_reset_mid_busy();
        bit seen;
        lhs = 32'd3; rhs = 32'd5; pw = 5'b00100; high = 1'b0; valid = 1'b1;
        @(posedge g_clk); #1;
        valid = 1'b0;
        repeat (3) @(posedge g_clk);
        #1;
        g_resetn = 1'b0;
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            if (ready) seen = 1'b1;
            @(posedge g_clk); #1;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL reset_mid_busy: got ready pulse want none");
        end
    endtask

    // Valid held through DONE: not accepted there, accepted in the IDLE that follows.
    task automatic test_back_to_back();
        int gap;
        lhs = 32'hFFFFFFFF; rhs = 32'hFFFFFFFF; pw = 5'b10000; high = 1'b0; valid = 1'b1;
        gap = 0;
        @(posedge g_clk); #1;
        while (!ready && gap < 40) begin
            @(posedge g_clk); #1;
            gap++;
        end
        total++;
        if (result !== 32'h55555555) begin
            bad++; $display("FAIL b2b_first: got %h want 55555555", result);
        end
        pw = 5'b01000; high = 1'b1;
        gap = 0;
        @(posedge g_clk); #1;
        gap = 1;
        while (!ready && gap < 40) begin
            @(posedge g_clk); #1;
            gap++;
        end
        valid = 1'b0;
        total++;
        if (result !== 32'hEEEEEEEE) begin
            bad++; $display("FAIL b2b_second: got %h want eeeeeeee", result);
        end
        total++;
        if (gap !== 6) begin
            bad++; $display("FAIL b2b_gap: got %0d want 6", gap);
        end
        @(posedge g_clk); #1;
    endtask

`ifdef P_MUL_ITER_CLMUL_EN
    task automatic test_clmul();
        logic [31:0] r; int lat; bit leak;
        clmul = 1'b1;
        run_op(32'd3, 32'd3, 5'b00001, 1'b0, r, lat, leak);
        @(posedge g_clk); #1;
        total++;
        if (r !== 32'h00000005) begin
            bad++; $display("FAIL clmul_3x3: got %h want 00000005", r);
        end
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00100, 1'b1, r, lat, leak);
        @(posedge g_clk); #1;
        total++;
        if (r !== 32'h55555555) begin
            bad++; $display("FAIL clmul_w8_hi: got %h want 55555555", r);
        end
        clmul = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_w32_small();
        test_w32_max();
        test_narrow_lanes();
        test_flush();
        test_reset_mid_busy();
        test_back_to_back();
`ifdef P_MUL_ITER_CLMUL_EN
        test_clmul();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
